byte_mem_ctrl: RTL and testbench
================================

BYTE_MEM_CTRL -- requirements
Module: byte_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 32: number of byte locations in the data store; must be a power of two.
REQ-002 Parameter AW, default 5: byte address width, equal to log2(DEPTH).
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req_valid  input  1: a load/store request is presented.
REQ-006 req_ready  output  1: the block can accept a request this cycle.
REQ-007 req_write  input  1: 1 = store word, 0 = load word.
REQ-008 req_addr  input  AW: byte address of the most significant byte.
REQ-009 req_wdata  input  32: store data.
REQ-010 rsp_valid  output  1: the response is available.
REQ-011 rsp_ready  input  1: the consumer accepts the response.
REQ-012 rsp_rdata  output  32: load data; all zeros for store responses.
REQ-013 rsp_write  output  1: echoes req_write of the completed request.
REQ-014 busy  output  1: high in any state other than IDLE.

Function
REQ-015 The store SHALL be DEPTH x 8-bit, big-endian: byte k of a word at address A is held at (A+k) mod DEPTH, with k=0 as bits 31:24.
REQ-016 The FSM SHALL have the states IDLE, XFER and RESP.
REQ-017 IDLE: req_ready=1; when req_valid=1, latch write, addr and wdata, clear byte index to 0, and go to XFER.
REQ-018 XFER: exactly one byte is transferred per cycle at address (addr+idx) mod DEPTH, for idx 0..3.
- Store: write wdata[31-8*idx -: 8].
- Load: read combinationally and shift the byte into the 32-bit capture register.
REQ-019 After the idx=3 transfer, the FSM SHALL go to RESP.
REQ-020 RESP: rsp_valid=1, with rsp_rdata and rsp_write held stable; when rsp_ready=1, go to IDLE.
REQ-021 Latency: request accepted in cycle C0 -> bytes transferred in C1..C4 -> rsp_valid first high in C5; with rsp_ready tied high, req_ready is high again in C6.
REQ-022 req_ready SHALL be 0 in XFER and RESP; req_valid in those states is ignored and not queued.
REQ-023 Address arithmetic is modulo DEPTH: an unaligned address or a wrapping address (e.g. 30) is legal and wraps to 0.
REQ-024 A load SHALL observe all bytes written by every previously completed store, including overlapping unaligned ones.
REQ-025 When rsp_ready=0, the block SHALL hold RESP indefinitely, with outputs unchanged.

Reset
REQ-026 While reset=1, the FSM SHALL go to IDLE, with idx=0 and a capture register of 0.
REQ-027 Output reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_write=0, busy=0.
REQ-028 Reset SHALL NOT clear the byte store; contents come only from initialisation and stores.
REQ-029 Reset during XFER aborts the request: bytes already written stay written, no response is issued, and no remaining bytes are written.
REQ-030 Reset takes priority over every simultaneous event, including req_valid in IDLE and rsp_ready in RESP.

Structure
REQ-031 A shared package SHALL hold:
- the FSM state enum (IDLE, XFER, RESP);
- the constants WORD_BYTES=4 and BYTE_W=8;
- the default DEPTH.
REQ-032 One sub-module, byte_ram, SHALL be used: DEPTH x 8 storage with a combinational read port and one synchronous write port.
REQ-033 The FSM, byte index counter, address adder and capture register SHALL live in byte_mem_ctrl.

Verification
REQ-034 Store addr=0, wdata=0xDEADBEEF, then load addr=0 -> bytes 0..3 = DE,AD,BE,EF; rsp_rdata=0xDEADBEEF, first high 5 cycles after acceptance.
REQ-035 Store addr=30, wdata=0x11223344 -> bytes 30=11, 31=22, 0=33, 1=44; load addr=30 returns 0x11223344.
REQ-036 Store addr=4 0xAABBCCDD, then store addr=6 0x01020304, then load addr=4 -> 0xAABB0102.
REQ-037 Hold rsp_ready=0 for 7 cycles in RESP while driving req_valid=1 -> rsp_valid and rsp_rdata stable, req_ready=0, no second request taken; then rsp_ready=1 -> IDLE next cycle.
REQ-038 Assert reset one cycle after a store of 0xCAFEF00D to addr=8 is accepted -> byte 8=CA and bytes 9..11 unchanged; outputs at reset values; no rsp_valid.
REQ-039 Back-to-back requests with rsp_ready=1 -> exactly one accepted every 6 cycles; busy low only in the acceptance cycles.

Source files
------------

// File: rtl/byte_mem_ctrl_pkg.sv
// Shared definitions for the byte-addressed word load/store controller.
//   state_t       : controller FSM states (IDLE, XFER, RESP)
//   WORD_BYTES    : bytes moved per load/store request
//   BYTE_W        : width of one storage location
//   DEFAULT_DEPTH : default number of byte locations in the store
package byte_mem_ctrl_pkg;

    localparam int WORD_BYTES    = 4;
    localparam int BYTE_W        = 8;
    localparam int DEFAULT_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/byte_ram.sv
// DEPTH x 8-bit byte store with a combinational read port and a synchronous
// write port sharing one address. The array has no reset: its contents only
// change through writes.
//   clk   : write clock
//   we    : write enable, byte written on the rising edge of clk
//   addr  : byte address for both read and write
//   wdata : byte to write
//   rdata : byte currently held at addr
module byte_ram
    import byte_mem_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [BYTE_W-1:0] wdata,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/byte_mem_ctrl.sv
// Word load/store controller over a byte-wide store. Each accepted request
// moves one byte per cycle for four cycles (big-endian: the byte at the
// request address is bits 31:24), then presents a response until consumed.
// Address arithmetic wraps modulo DEPTH.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where rsp_valid
// and rsp_ready are both 1. Only one request is in flight; req_valid while
// req_ready=0 is ignored, never queued. Response fields are held stable while
// rsp_valid=1 and rsp_ready=0.
//
//   clk, reset           : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake
//   req_write            : 1 = store word, 0 = load word
//   req_addr             : byte address of the most significant byte
//   req_wdata            : store data
//   rsp_valid/rsp_ready  : response handshake
//   rsp_rdata            : load data (zero for stores)
//   rsp_write            : req_write of the completed request
//   busy                 : high whenever the FSM is not in IDLE
//   dbg_state            : current FSM state encoding
module byte_mem_ctrl
    import byte_mem_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_write,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    state_t        state;
    logic [1:0]    idx;
    logic          write_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   capture;
    logic [31:0]   capture_next;

    logic [AW-1:0]     ram_addr;
    logic              ram_we;
    logic [BYTE_W-1:0] ram_wdata;
    logic [BYTE_W-1:0] ram_rdata;

    // Natural AW-bit overflow gives the modulo-DEPTH wrap.
    assign ram_addr = addr_q + AW'(idx);

    // Reset gates the write so an aborted store stops on the reset edge.
    assign ram_we = (state == XFER) && write_q && !reset;

    always_comb begin
        ram_wdata = wdata_q[31:24];
        case (idx)
            2'd0:    ram_wdata = wdata_q[31:24];
            2'd1:    ram_wdata = wdata_q[23:16];
            2'd2:    ram_wdata = wdata_q[15:8];
            default: ram_wdata = wdata_q[7:0];
        endcase
    end

    // Loads shift bytes in from the right, so after four bytes the first one
    // read sits in bits 31:24.
    assign capture_next = {capture[23:0], ram_rdata};

    byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            capture   <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_write <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        idx       <= 2'd0;
                        capture   <= '0;
                        state     <= XFER;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                XFER: begin
                    if (!write_q) begin
                        capture <= capture_next;
                    end
                    idx <= idx + 2'd1;
                    if (idx == LAST_IDX) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_write <= write_q;
                        rsp_rdata <= write_q ? 32'h0 : capture_next;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Bench for byte_mem_ctrl: directed scenarios plus random traffic. A driver
// pushes the expected response of each accepted request into exp_q (computed
// from a byte-array model of the store); a monitor pops and compares on each
// response handshake and checks the acceptance-to-response latency.
module tb_byte_mem_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_write;
    logic          busy;
    logic [1:0]    dbg_state;

    byte_mem_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_write (rsp_write),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [32:0] exp_q[$];   // {rsp_write, rsp_rdata}
    int          acc_q[$];   // cycle index of each accepted request
    logic [7:0]  mem_model [DEPTH];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
    endtask

    // Reference behaviour: a word at A covers bytes (A+k) mod DEPTH, k=0 is MSB.
    task automatic note_accept(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
        logic [31:0] v;
        int          loc;
        v = 32'h0;
        for (int k = 0; k < 4; k++) begin
            loc = (int'(a) + k) % DEPTH;
            if (w) mem_model[loc] = 8'(d >> (24 - 8 * k));
            else   v = v | (32'(mem_model[loc]) << (24 - 8 * k));
        end
        exp_q.push_back(w ? {1'b1, 32'h0} : {1'b0, v});
        acc_q.push_back(cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_rsp_write"}, 32'(rsp_write), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // ---------------- monitor ----------------
    logic        prev_valid = 1'b0;
    logic [32:0] mon_exp;
    int          mon_acc;

    always @(negedge clk) begin
        if (rsp_valid && !prev_valid) begin
            if (acc_q.size() == 0) fail_now("latency_no_request");
            else begin
                mon_acc = acc_q.pop_front();
                check("rsp_latency", 32'(cyc - mon_acc), 32'd5);
            end
        end
        prev_valid = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected_response");
            else begin
                mon_exp = exp_q.pop_front();
                check("rsp_write", 32'(rsp_write), 32'(mon_exp[32]));
                check("rsp_rdata", rsp_rdata, mon_exp[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && req_ready) begin seen = 1; break; end
        end
        if (!seen) fail_now(name);
    endtask

    // One request; stall = cycles rsp_ready stays low once rsp_valid appears.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [31:0] d, input int stall);
        bit ok = 0;
        @(posedge clk); #1;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        rsp_ready = (stall == 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin note_accept(w, a, d); ok = 1; break; end
        end
        if (!ok) fail_now("accept_timeout");
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (stall > 0) begin
            ok = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rsp_valid) begin ok = 1; break; end
            end
            if (!ok) fail_now("rsp_valid_timeout");
            repeat (stall) @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        wait_idle("idle_timeout");
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] held;
    int          last_acc;
    int          n_acc;
    bit          ok;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 reset = 1'b0;

        // Give every byte a known value.
        for (int i = 0; i < DEPTH; i += 4) send(1'b1, AW'(i), 32'h0, 0);

        // Aligned store/load.
        send(1'b1, 5'd0, 32'hDEADBEEF, 0);
        send(1'b0, 5'd0, 32'h0, 0);

        // Wrapping store at 30, then loads across the wrap point.
        send(1'b1, 5'd30, 32'h11223344, 0);
        send(1'b0, 5'd30, 32'h0, 0);
        send(1'b0, 5'd0, 32'h0, 0);

        // Overlapping unaligned stores.
        send(1'b1, 5'd4, 32'hAABBCCDD, 0);
        send(1'b1, 5'd6, 32'h01020304, 0);
        send(1'b0, 5'd4, 32'h0, 0);

        // Response backpressure with a competing request held on req_valid.
        @(posedge clk); #1;
        req_write = 1'b0; req_addr = 5'd4; req_wdata = 32'h0; req_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        if (req_ready) note_accept(1'b0, 5'd4, 32'h0);
        else fail_now("hold_accept");
        @(posedge clk); #1;
        req_write = 1'b1; req_addr = 5'd4; req_wdata = 32'h55555555;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) fail_now("hold_rsp_valid");
        held = rsp_rdata;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_rdata", rsp_rdata, held);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("hold_release_req_ready", 32'(req_ready), 32'd1);
        check("hold_release_busy", 32'(busy), 32'd0);
        send(1'b0, 5'd4, 32'h0, 0);

        // Reset during a store to 8: only byte 8 lands.
        @(posedge clk); #1;
        req_write = 1'b1; req_addr = 5'd8; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(negedge clk);
        check("abort_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk); #1 reset = 1'b0;
        mem_model[8] = 8'hCA;
        repeat (6) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        send(1'b0, 5'd8, 32'h0, 0);

        // Back-to-back requests with req_valid held high.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_write = 1'($urandom_range(0, 1)); req_addr = AW'($urandom_range(0, DEPTH - 1));
        req_wdata = $urandom; req_valid = 1'b1;
        n_acc = 0; last_acc = 0;
        for (int g = 0; g < 100 && n_acc < 6; g++) begin
            @(negedge clk);
            if (req_ready) begin
                note_accept(req_write, req_addr, req_wdata);
                check("b2b_busy_low", 32'(busy), 32'd0);
                if (n_acc > 0) check("b2b_gap", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                n_acc++;
                @(posedge clk); #1;
                if (n_acc < 6) begin
                    req_write = 1'($urandom_range(0, 1));
                    req_addr  = AW'($urandom_range(0, DEPTH - 1));
                    req_wdata = $urandom;
                end else req_valid = 1'b0;
            end else begin
                check("b2b_busy_high", 32'(busy), 32'd1);
            end
        end
        if (n_acc < 6) fail_now("b2b_accepts");
        req_valid = 1'b0;
        wait_idle("b2b_idle");

        // Random traffic with occasional response stalls.
        for (int i = 0; i < 40; i++) begin
            send(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        repeat (4) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
